muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Replaces the single-cycle combinational mul/div path with a shift-add / restoring-divide engine.
//  Sits beside the ALU in EX and accepts the same 5-bit operation codes.
//  Uses a valid/ready handshake so the pipeline stalls while the block is busy.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (32 or 64)
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid; op_a/op_b/operation are stable while high
//  in_ready   out  1      block idle and able to accept a request
//  operation  in   5      ALU op code; only 01010..10001 are legal
//  op_a       in   WIDTH  rs1 value
//  op_b       in   WIDTH  rs2 value
//  flush      in   1      synchronous abort; drops the op in flight
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  result     out  WIDTH  result value
//  error      out  1      request carried an illegal op code (result = 0)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, result=0, error=0. Internal registers cleared.
//  A request is accepted on a cycle where in_valid & in_ready. Operands, op and sign flags are latched then.
//  FSM states and transitions:
//   - IDLE: on accept, go to CALC (legal op) or DONE (illegal op, error=1). Set cnt=WIDTH-1.
//   - CALC: one bit per cycle for WIDTH cycles; cnt decrements; go to FIXUP when cnt==0.
//   - FIXUP: apply sign correction and select the result half; go to DONE.
//   - DONE: out_valid=1. On out_ready, go to IDLE.
//  in_ready=1 only in IDLE. Back-to-back: a new accept is possible on the cycle after DONE handshakes.
//  Latency: out_valid rises WIDTH+2 cycles after the accept edge. Illegal op: 1 cycle after accept.
//  MUL family:
//   - The engine multiplies |a| by |b| into a 2*WIDTH accumulator by shift-add.
//   - Signedness: MUL/MULH treat a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
//   - The 2*WIDTH product is negated when the operand signs differ.
//   - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
//  DIV family:
//   - Restoring division of |a| by |b|. Signed for DIV/REM, unsigned for DIVU/REMU.
//   - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
//   - Divide by zero: quotient = all ones, remainder = op_a.
//   - Signed overflow (MIN / -1): quotient = MIN, remainder = 0. Handled in FIXUP; the engine result is overridden.
//  flush:
//   - In any state: next state is IDLE, out_valid=0, and the result is discarded.
//   - flush has priority over out_ready and over in_valid in the same cycle.
//   - flush while IDLE with in_valid: the request is not accepted.
//  Async reset mid-operation: immediate return to the reset state; no partial result is ever presented.
//  result/error are stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: these cases skip CALC and FIXUP and go straight to DONE (out_valid 1 cycle after accept):
//   - div/rem with op_b==0
//   - mul-family with op_a==0 or op_b==0
//  Results are identical to the full path.
//  Undefined: every legal op takes WIDTH+2 cycles (fixed latency).
// STRUCTURE
//  Shared package alu_pkg holds:
//   - the 5-bit op code localparams (ALU_ADD..ALU_REMU), shared with the ALU
//   - the FSM state encoding: IDLE=2'd0, CALC=2'd1, FIXUP=2'd2, DONE=2'd3
//  Sub-module muldiv_step (combinational): one shift-add / one restoring-subtract iteration on the accumulator.
//  The FSM, counter and sign-fix logic stay in muldiv_seq.
// TESTING (WIDTH=32)
//  1. MUL a=7, b=-3: result=0xFFFFFFEB, out_valid exactly 34 cycles after accept (macro off).
//  2. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULH a=0x80000000, b=0x80000000 -> 0x40000000.
//  3. DIV/REM -7 by 2 -> 0xFFFFFFFD / 0xFFFFFFFF. DIVU 100 by 0 -> 0xFFFFFFFF. REM 0x80000000 by -1 -> 0.
//  4. op=5'b00000 (ADD): error=1, result=0, out_valid 1 cycle after accept. Next legal op clears error.
//  5. Hold out_ready=0 for 5 cycles in DONE: result and out_valid stable, in_ready=0. Pulse flush mid-CALC: IDLE next cycle, no out_valid.
//  6. Assert rst_n=0 mid-CALC: outputs take reset values asynchronously. With MULDIV_EARLY_OUT_EN, DIV by 0 returns all ones in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 5-bit operation codes used by both the ALU and the
// multi-cycle multiply/divide sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldivState_t;

    // True for the eight M-extension codes handled by the sequencer
    function automatic logic isMulDivOp(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    // True for the division/remainder half of the M-extension codes
    function automatic logic isDivOp(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide engine on the 2*WIDTH accumulator.
// Multiply: accumulator is {partial product, remaining multiplier bits};
// add the multiplicand when the multiplier LSB is set, then shift right.
// Divide: accumulator is {partial remainder, remaining dividend / quotient};
// shift left one bit and keep the trial subtraction if it did not borrow.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 isDiv_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] remTrial;
    logic [WIDTH:0] diff;

    // Single shift-add or restoring-subtract step selected by isDiv_i
    always_comb begin
        acc_o    = acc_i;
        sum      = '0;
        remTrial = '0;
        diff     = '0;
        if (!isDiv_i) begin
            sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                    (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            remTrial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
            diff     = remTrial - {1'b0, operand_i};
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {remTrial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for the RV M-extension ops (MUL..REMU) sitting beside
// the ALU in EX. Operands are latched as magnitudes, run through WIDTH
// iterations of muldiv_step, then sign-corrected in FIXUP.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide by zero and multiply
// by zero finish straight from IDLE to DONE with the same results.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    muldivState_t       state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   aRaw_q, aRaw_d;
    logic [4:0]         op_q, op_d;
    logic               negQ_q, negQ_d;
    logic               negR_q, negR_d;
    logic               divZero_q, divZero_d;
    logic               divOvf_q, divOvf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               error_q, error_d;

    logic               accept;
    logic               aSigned, bSigned, aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] stepAcc;
    logic [2*WIDTH-1:0] prodFixed;
    logic               opIsDiv;

    assign opIsDiv = isDivOp(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i   (opIsDiv),
        .acc_i     (acc_q),
        .operand_i (divisor_q),
        .acc_o     (stepAcc)
    );

    // Operand signedness and magnitudes for the incoming request
    always_comb begin
        aSigned = (operation == ALU_MUL) || (operation == ALU_MULH) ||
                  (operation == ALU_MULHSU) || (operation == ALU_DIV) ||
                  (operation == ALU_REM);
        bSigned = (operation == ALU_MUL) || (operation == ALU_MULH) ||
                  (operation == ALU_DIV) || (operation == ALU_REM);
        aNeg    = aSigned && op_a[WIDTH-1];
        bNeg    = bSigned && op_b[WIDTH-1];
        aMag    = aNeg ? -op_a : op_a;
        bMag    = bNeg ? -op_b : op_b;
    end

    // Next-state, datapath update and sign fix-up; flush overrides everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        aRaw_d    = aRaw_q;
        op_d      = op_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        divZero_d = divZero_q;
        divOvf_d  = divOvf_q;
        result_d  = result_q;
        error_d   = error_q;
        prodFixed = negQ_q ? -acc_q : acc_q;
        accept    = in_valid && (state_q == IDLE) && !flush;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CntW'(WIDTH - 1);
                    if (!isMulDivOp(operation)) begin
                        state_d  = DONE;
                        error_d  = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d   = CALC;
                        error_d   = 1'b0;
                        op_d      = operation;
                        negQ_d    = aNeg ^ bNeg;
                        negR_d    = aNeg;
                        aRaw_d    = op_a;
                        divisor_d = bMag;
                        acc_d     = {{WIDTH{1'b0}}, aMag};
                        divZero_d = (op_b == '0);
                        divOvf_d  = ((operation == ALU_DIV) || (operation == ALU_REM)) &&
                                    (op_a == MinVal) && (op_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
                        if (isDivOp(operation) && (op_b == '0)) begin
                            state_d  = DONE;
                            result_d = ((operation == ALU_DIV) || (operation == ALU_DIVU)) ?
                                       '1 : op_a;
                        end else if (!isDivOp(operation) &&
                                     ((op_a == '0) || (op_b == '0))) begin
                            state_d  = DONE;
                            result_d = '0;
                        end
`endif
                    end
                end
            end
            CALC: begin
                acc_d = stepAcc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = DONE;
                case (op_q)
                    ALU_MUL: result_d = prodFixed[WIDTH-1:0];
                    ALU_MULH, ALU_MULHSU, ALU_MULHU:
                        result_d = prodFixed[2*WIDTH-1:WIDTH];
                    ALU_DIV, ALU_DIVU: begin
                        if (divZero_q) begin
                            result_d = '1;
                        end else if (divOvf_q) begin
                            result_d = MinVal;
                        end else begin
                            result_d = negQ_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        end
                    end
                    ALU_REM, ALU_REMU: begin
                        if (divZero_q) begin
                            result_d = aRaw_q;
                        end else if (divOvf_q) begin
                            result_d = '0;
                        end else begin
                            result_d = negR_q ? -acc_q[2*WIDTH-1:WIDTH]
                                              : acc_q[2*WIDTH-1:WIDTH];
                        end
                    end
                    default: result_d = '0;
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = '0;
            error_d  = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            divisor_q <= '0;
            aRaw_q    <= '0;
            op_q      <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            divZero_q <= 1'b0;
            divOvf_q  <= 1'b0;
            result_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            aRaw_q    <= aRaw_d;
            op_q      <= op_d;
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            divZero_q <= divZero_d;
            divOvf_q  <= divOvf_d;
            result_q  <= result_d;
            error_q   <= error_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign error     = error_q;

endmodule
